// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared types and constants for the instruction/data memory port arbiter.
// Contents:
//   arb_state_t  arbiter FSM states
//   NOP_INSTR    instruction returned to the fetch side when a transfer is aborted
//   BE_FULL      byte-enable value used for fetches and loads
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      I_XFER = 2'd1,
      D_XFER = 2'd2
   } arb_state_t;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   localparam logic [3:0]  BE_FULL   = 4'hF;

endpackage

// File: rtl/arb_timeout_cnt.sv
// arb_timeout_cnt
// Watchdog down-counter.
// load_i reloads LOAD_VAL. en_i decrements the count, which saturates at zero.
// tc_o is high while the count is zero.
// Ports:
//   clk     clock, rising edge
//   n_rst   asynchronous active-low reset (count -> 0)
//   load_i  reload LOAD_VAL (has priority over en_i)
//   en_i    decrement enable
//   tc_o    terminal count (count == 0)
module arb_timeout_cnt #(
   parameter int unsigned LOAD_VAL = 64
) (
   input  logic clk,
   input  logic n_rst,
   input  logic load_i,
   input  logic en_i,
   output logic tc_o
);

   localparam int unsigned W = (LOAD_VAL < 1) ? 1 : $clog2(LOAD_VAL + 1);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= W'(LOAD_VAL);
      end else if (en_i && (cnt_q != '0)) begin
         cnt_q <= cnt_q - W'(1);
      end
   end

   assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port memory bus between instruction fetch (i_*) and the
// load/store unit (d_*). One transfer is granted at a time. The request
// fields are latched at grant time and held on m_* until m_ready, or until
// the watchdog aborts the transfer. Data wins ties because it belongs to
// the older instruction.
//
// Optional build macro ARB_STARVE_GUARD_EN:
//   After MAX_D_STREAK consecutive data grants made while a fetch is
//   waiting, the next grant goes to the fetch.
//   Without the macro, data has strict priority.
//
// Ports:
//   clk, n_rst                 clock / async active-low reset
//   i_req, i_addr              fetch request (level) and address
//   i_ack, i_rdata             fetch done pulse, fetched word
//   d_req, d_we, d_addr,
//   d_wdata, d_be              load/store request and fields
//   d_ack, d_rdata             data done pulse, load data
//   m_req, m_we, m_addr,
//   m_wdata, m_be              memory bus request side (registered)
//   m_rdata, m_ready           memory bus response
//   stall                      a request is pending and not yet acked
//   err                        pulses with the ack of an aborted transfer
//
// state  | meaning
// IDLE   | bus free; arbitrate; also the mandatory gap after each completion
// I_XFER | fetch transfer on the bus, waiting for m_ready or the watchdog
// D_XFER | load/store transfer on the bus, waiting for m_ready or the watchdog
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC  = 64,
   parameter int unsigned MAX_D_STREAK = 4
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_ack,
   output logic [31:0] i_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_be,
   output logic        d_ack,
   output logic [31:0] d_rdata,
   output logic        m_req,
   output logic        m_we,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   output logic [3:0]  m_be,
   input  logic [31:0] m_rdata,
   input  logic        m_ready,
   output logic        stall,
   output logic        err
);

   localparam bit WD_ON = (TIMEOUT_CYC != 0);

   if (MAX_D_STREAK < 1) begin : g_bad_streak
      $error("MAX_D_STREAK must be at least 1");
   end

   arb_state_t  state_q;
   logic        m_req_q;
   logic        m_we_q;
   logic [31:0] m_addr_q;
   logic [31:0] m_wdata_q;
   logic [3:0]  m_be_q;
   logic [31:0] i_rdata_q;
   logic [31:0] d_rdata_q;

   logic        in_xfer;
   logic        starve;
   logic        grant_d;
   logic        grant_i;
   logic        wd_tc;
   logic        timeout;
   logic        done;
   logic [31:0] xfer_rdata;

`ifdef ARB_STARVE_GUARD_EN
   localparam int unsigned SW = $clog2(MAX_D_STREAK + 1);

   logic [SW-1:0] streak_q;

   // Streak only grows while a fetch is actually waiting, so it can never
   // pass MAX_D_STREAK: at that value a waiting fetch wins the next grant.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         streak_q <= '0;
      end else if (grant_i) begin
         streak_q <= '0;
      end else if (grant_d && i_req) begin
         streak_q <= streak_q + SW'(1);
      end
   end

   assign starve = i_req & (streak_q == SW'(MAX_D_STREAK));
`else
   assign starve = 1'b0;
`endif

   assign in_xfer = (state_q != IDLE);
   assign grant_d = (state_q == IDLE) & d_req & ~starve;
   assign grant_i = (state_q == IDLE) & i_req & ~grant_d;

   // Loaded at grant, counts down on each transfer cycle without m_ready.
   // The abort fires in the transfer cycle after TIMEOUT_CYC such cycles.
   arb_timeout_cnt #(
      .LOAD_VAL (TIMEOUT_CYC)
   ) u_wd (
      .clk    (clk),
      .n_rst  (n_rst),
      .load_i (grant_i | grant_d),
      .en_i   (in_xfer & ~m_ready),
      .tc_o   (wd_tc)
   );

   // A late m_ready in the abort cycle still counts as a normal completion.
   assign timeout    = WD_ON & in_xfer & wd_tc & ~m_ready;
   assign done       = in_xfer & (m_ready | timeout);
   assign xfer_rdata = m_ready ? m_rdata : NOP_INSTR;

   assign i_ack   = done & (state_q == I_XFER);
   assign d_ack   = done & (state_q == D_XFER);
   assign err     = timeout;
   assign i_rdata = i_ack ? xfer_rdata : i_rdata_q;
   assign d_rdata = d_ack ? xfer_rdata : d_rdata_q;
   assign stall   = (i_req & ~i_ack) | (d_req & ~d_ack);

   assign m_req   = m_req_q;
   assign m_we    = m_we_q;
   assign m_addr  = m_addr_q;
   assign m_wdata = m_wdata_q;
   assign m_be    = m_be_q;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q   <= IDLE;
         m_req_q   <= 1'b0;
         m_we_q    <= 1'b0;
         m_addr_q  <= '0;
         m_wdata_q <= '0;
         m_be_q    <= '0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (grant_d) begin
                  state_q   <= D_XFER;
                  m_req_q   <= 1'b1;
                  m_we_q    <= d_we;
                  m_addr_q  <= d_addr;
                  m_wdata_q <= d_wdata;
                  m_be_q    <= d_we ? d_be : BE_FULL;
               end else if (grant_i) begin
                  state_q  <= I_XFER;
                  m_req_q  <= 1'b1;
                  m_we_q   <= 1'b0;
                  m_addr_q <= i_addr;
                  m_be_q   <= BE_FULL;
               end
            end
            I_XFER: begin
               if (done) begin
                  state_q   <= IDLE;
                  m_req_q   <= 1'b0;
                  m_we_q    <= 1'b0;
                  i_rdata_q <= xfer_rdata;
               end
            end
            D_XFER: begin
               if (done) begin
                  state_q   <= IDLE;
                  m_req_q   <= 1'b0;
                  m_we_q    <= 1'b0;
                  d_rdata_q <= xfer_rdata;
               end
            end
            default: begin
               state_q <= IDLE;
               m_req_q <= 1'b0;
               m_we_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Randomized and directed stimulus for mem_port_arbiter, checked each cycle
// against a transaction-level reference model.
// The model tracks:
//   - who owns the bus
//   - how long the owner has waited
//   - the latched request fields
//   - the last rdata returned to each side
module tb_mem_port_arbiter;

   localparam int TO   = 8;
   localparam int MAXS = 4;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        n_rst;
   logic        i_req, d_req, d_we, m_ready;
   logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
   logic [3:0]  d_be;
   logic        i_ack, d_ack, m_req, m_we, stall, err;
   logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
   logic [3:0]  m_be;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .TIMEOUT_CYC  (TO),
      .MAX_D_STREAK (MAXS)
   ) dut (
      .clk     (clk),
      .n_rst   (n_rst),
      .i_req   (i_req),
      .i_addr  (i_addr),
      .i_ack   (i_ack),
      .i_rdata (i_rdata),
      .d_req   (d_req),
      .d_we    (d_we),
      .d_addr  (d_addr),
      .d_wdata (d_wdata),
      .d_be    (d_be),
      .d_ack   (d_ack),
      .d_rdata (d_rdata),
      .m_req   (m_req),
      .m_we    (m_we),
      .m_addr  (m_addr),
      .m_wdata (m_wdata),
      .m_be    (m_be),
      .m_rdata (m_rdata),
      .m_ready (m_ready),
      .stall   (stall),
      .err     (err)
   );

   int n_cmp = 0;
   int n_mis = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h at t=%0t", tag, obs, exp, $time);
      end
   endtask

   // Model state. owner: 0 = bus free, 1 = fetch, 2 = data.
   int          owner;
   int          waited;
   int          streak;
   logic        q_we;
   logic [31:0] q_addr, q_wdata;
   logic [3:0]  q_be;
   logic [31:0] last_i, last_d;
   logic        e_i_ack, e_d_ack, e_err;
   int          n_iack_seen;

   task automatic model_reset();
      owner   = 0;
      waited  = 0;
      streak  = 0;
      q_we    = 1'b0;
      q_addr  = '0;
      q_wdata = '0;
      q_be    = '0;
      last_i  = '0;
      last_d  = '0;
   endtask

   // One clock: outputs are checked at negedge, and the model advances at
   // posedge. Entered and left at posedge+1, so inputs are stable throughout.
   task automatic step();
      logic        tmo, fire, guard;
      logic [31:0] rd;
      @(negedge clk);
      tmo     = (owner != 0) && !m_ready && (TO != 0) && (waited == TO);
      fire    = (owner != 0) && (m_ready || tmo);
      rd      = m_ready ? m_rdata : NOP;
      e_i_ack = fire && (owner == 1);
      e_d_ack = fire && (owner == 2);
      e_err   = tmo;
      if (i_ack) n_iack_seen++;
      chk("m_req",   32'(m_req),   32'(owner != 0));
      chk("i_ack",   32'(i_ack),   32'(e_i_ack));
      chk("d_ack",   32'(d_ack),   32'(e_d_ack));
      chk("err",     32'(err),     32'(e_err));
      chk("i_rdata", i_rdata,      e_i_ack ? rd : last_i);
      chk("d_rdata", d_rdata,      e_d_ack ? rd : last_d);
      chk("stall",   32'(stall),   32'((i_req && !e_i_ack) || (d_req && !e_d_ack)));
      if (owner != 0) begin
         chk("m_we",   32'(m_we), 32'(q_we));
         chk("m_addr", m_addr,    q_addr);
         chk("m_be",   32'(m_be), 32'(q_be));
         if (q_we) chk("m_wdata", m_wdata, q_wdata);
      end
      @(posedge clk);
      if (fire) begin
         if (owner == 1) last_i = rd;
         else            last_d = rd;
         owner = 0;
      end else if (owner != 0) begin
         waited++;
      end else begin
         guard = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
         guard = i_req && (streak == MAXS);
`endif
         if (d_req && !guard) begin
            owner   = 2;
            q_we    = d_we;
            q_addr  = d_addr;
            q_wdata = d_wdata;
            q_be    = d_we ? d_be : 4'hF;
            waited  = 0;
            if (i_req) streak++;
         end else if (i_req) begin
            owner  = 1;
            q_we   = 1'b0;
            q_addr = i_addr;
            q_be   = 4'hF;
            waited = 0;
            streak = 0;
         end
      end
      #1;
   endtask

   // Steps n cycles; each requester drops its request once acked.
   task automatic run_drop(input int n);
      for (int k = 0; k < n; k++) begin
         step();
         if (e_i_ack) i_req = 1'b0;
         if (e_d_ack) d_req = 1'b0;
      end
   endtask

   task automatic new_d();
      d_we    = $urandom_range(0, 1) == 1;
      d_addr  = $urandom;
      d_wdata = $urandom;
      d_be    = 4'($urandom_range(0, 15));
   endtask

   int n_before;

   initial begin
      n_rst = 1'b0;
      i_req = 0; d_req = 0; d_we = 0; m_ready = 0;
      i_addr = '0; d_addr = '0; d_wdata = '0; d_be = '0; m_rdata = '0;
      n_iack_seen = 0;
      model_reset();
      e_i_ack = 0; e_d_ack = 0; e_err = 0;
      #1;
      step();
      chk("rst_m_addr",  m_addr,       32'h0);
      chk("rst_m_wdata", m_wdata,      32'h0);
      chk("rst_m_be",    32'(m_be),    32'h0);
      chk("rst_m_we",    32'(m_we),    32'h0);
      n_rst = 1'b1;

      // Lone fetch
      i_req = 1; i_addr = 32'h1000_0000; m_ready = 1; m_rdata = 32'h0000_0033;
      run_drop(3);
      chk("lone_i_rdata", i_rdata, 32'h0000_0033);

      // Collision: store wins; the fetch follows after one idle cycle
      m_ready = 0; i_req = 1; i_addr = 32'h0000_4000;
      d_req = 1; d_we = 1; d_addr = 32'h0000_2000; d_wdata = 32'hCAFE_F00D; d_be = 4'b0011;
      run_drop(3);
      m_ready = 1; m_rdata = 32'h1234_5678;
      run_drop(4);

      // Timeout: fetch with the bus never ready
      m_ready = 0; i_req = 1; i_addr = 32'h0000_8000;
      run_drop(TO + 3);
      chk("tmo_i_rdata", i_rdata, NOP);

      // Timeout race: m_ready lands exactly in the abort cycle
      i_req = 1; i_addr = 32'h0000_9000;
      for (int k = 0; k < TO + 1; k++) step();
      m_ready = 1; m_rdata = 32'hA5A5_0001;
      run_drop(2);
      chk("race_i_rdata", i_rdata, 32'hA5A5_0001);

      // Reset during a data transfer
      m_ready = 0; d_req = 1; d_we = 0; d_addr = 32'h0000_3000;
      step(); step();
      #2 n_rst = 1'b0;
      #1;
      chk("rst_mid_m_req", 32'(m_req), 32'h0);
      chk("rst_mid_d_ack", 32'(d_ack), 32'h0);
      model_reset();
      @(posedge clk);
      #1 n_rst = 1'b1;
      m_ready = 1; m_rdata = 32'h0BAD_CAFE;
      run_drop(4);
      chk("rst_regrant_d_rdata", d_rdata, 32'h0BAD_CAFE);

      // Both requesters held continuously
      i_req = 1; d_req = 1; i_addr = 32'h0000_7770; d_addr = 32'h0000_5550;
      d_we = 0; m_ready = 1;
      n_before = n_iack_seen;
      for (int k = 0; k < 30; k++) step();
`ifdef ARB_STARVE_GUARD_EN
      chk("starve_fetch_grants", 32'(n_iack_seen - n_before), 32'd3);
`else
      chk("starve_fetch_grants", 32'(n_iack_seen - n_before), 32'd0);
`endif
      i_req = 0; d_req = 0;
      run_drop(3);

      // Randomized traffic with periodic bus hangs
      for (int c = 0; c < 3000; c++) begin
         m_ready = ((c % 100) >= 85) ? 1'b0 : ($urandom_range(0, 2) == 0);
         m_rdata = $urandom;
         step();
         if (e_i_ack || !i_req) begin
            i_req  = $urandom_range(0, 3) != 0;
            i_addr = $urandom;
         end else if ($urandom_range(0, 31) == 0) begin
            i_req = 1'b0;
         end
         if (e_d_ack || !d_req) begin
            d_req = $urandom_range(0, 2) != 0;
            new_d();
         end else if ($urandom_range(0, 31) == 0) begin
            d_req = 1'b0;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
